// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL power-up and lock qualification sequencer.
// Holds the PLL in power-down, waits for lock, requires a run of
// consecutive locked cycles before releasing the fabric reset, and gives up
// after a bounded number of lock timeouts.
// Build option: define PLL_SUP_LOSS_CNT_EN to include the loss-of-lock
// counter on loss_cnt_o; otherwise loss_cnt_o is tied to zero.
//
// state  | meaning
// PD     | PLL held in power-down for PD_CYCLES cycles
// WAIT   | PLL powered, waiting up to LOCK_TIMEOUT cycles for lock
// STABLE | lock seen, counting STABLE_CYCLES consecutive locked cycles
// RUN    | lock qualified, fabric reset released
// FAULT  | retry budget exhausted, PLL powered down until retry_req_i

module pll_lock_supervisor #(
   parameter int unsigned PD_CYCLES     = 16,
   parameter int unsigned LOCK_TIMEOUT  = 4096,
   parameter int unsigned STABLE_CYCLES = 256,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       pll_lock_i,
   input  logic       retry_req_i,
   output logic       pll_powerdown_n_o,
   output logic       fab_rst_n_o,
   output logic       fault_o,
   output logic [2:0] state_o,
   output logic [3:0] retry_cnt_o,
   output logic [7:0] loss_cnt_o
);

   typedef enum logic [2:0] {
      ST_PD     = 3'd0,
      ST_WAIT   = 3'd1,
      ST_STABLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_FAULT  = 3'd4
   } state_e;

   localparam logic [15:0] PD_LAST      = 16'(PD_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
   localparam logic [15:0] RETRY_LIMIT  = 16'(MAX_RETRIES);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  retry_q, retry_d;
   logic        pd_n_q, fab_q, fault_q;
   logic [1:0]  sync_q;
   logic        lock_s;
   logic        pll_off;

   // While the PLL is powered down its lock output is meaningless, so the
   // synchronizer is held clear; WAIT only reacts to a lock raised after
   // power-up.
   assign pll_off = (state_q == ST_PD) || (state_q == ST_FAULT);

   // Two-flop synchronizer for the asynchronous PLL lock indication.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= 2'b00;
      end else if (pll_off) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], pll_lock_i};
      end
   end

   assign lock_s = sync_q[1];

   // Next-state, shared cycle counter and retry bookkeeping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      retry_d = retry_q;
      case (state_q)
         ST_PD: begin
            if (cnt_q == PD_LAST) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            if (lock_s) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               cnt_d = '0;
               if ({12'd0, retry_q} == RETRY_LIMIT) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_PD;
                  if (retry_q != 4'hF) begin
                     retry_d = retry_q + 4'd1;
                  end
               end
            end
         end
         ST_STABLE: begin
            // Loss of lock wins over a completing count.
            if (!lock_s) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               retry_d = '0;
            end
         end
         ST_RUN: begin
            cnt_d = '0;
            if (!lock_s) begin
               state_d = ST_PD;
            end
         end
         ST_FAULT: begin
            cnt_d = '0;
            if (retry_req_i) begin
               state_d = ST_PD;
               retry_d = '0;
            end
         end
         default: begin
            state_d = ST_PD;
            cnt_d   = '0;
         end
      endcase
   end

   // State register with outputs registered from the next-state decode, so
   // each output changes on the same edge as the state it belongs to.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_PD;
         cnt_q   <= '0;
         retry_q <= '0;
         pd_n_q  <= 1'b0;
         fab_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         pd_n_q  <= (state_d == ST_WAIT) || (state_d == ST_STABLE) ||
                    (state_d == ST_RUN);
         fab_q   <= (state_d == ST_RUN);
         fault_q <= (state_d == ST_FAULT);
      end
   end

   assign pll_powerdown_n_o = pd_n_q;
   assign fab_rst_n_o       = fab_q;
   assign fault_o           = fault_q;
   assign state_o           = state_q;
   assign retry_cnt_o       = retry_q;

`ifdef PLL_SUP_LOSS_CNT_EN
   logic [7:0] loss_q;

   // Count RUN exits; RUN is only ever left because lock was lost.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         loss_q <= '0;
      end else if ((state_q == ST_RUN) && (state_d == ST_PD) &&
                   (loss_q != 8'hFF)) begin
         loss_q <= loss_q + 8'd1;
      end
   end

   assign loss_cnt_o = loss_q;
`else
   assign loss_cnt_o = 8'd0;
`endif

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset, listed first in the port list.
REQ-002 CLK  in  1  free-running PLL reference clock; the same net drives the PLL REF_CLK input.
REQ-003 RST_N  in  1  asynchronous active-low reset.
REQ-004 PLL_LOCK  in  1  raw PLL lock indication, asynchronous to CLK.
REQ-005 RETRY_REQ  in  1  single-cycle pulse that restarts the sequence from FAULT.
REQ-006 PLL_POWERDOWN_N  out  1  drives the PLL power-down input; 0 holds the PLL in power-down.
REQ-007 FAB_RST_N  out  1  fabric reset request; 1 only when the lock is stable.
REQ-008 FAULT  out  1  retry budget exhausted.
REQ-009 STATE  out  3  encoded FSM state: PD=0, WAIT=1, STABLE=2, RUN=3, FAULT=4.
REQ-010 RETRY_CNT  out  4  number of lock timeouts since the last successful RUN entry.
REQ-011 LOSS_CNT  out  8  count of lock losses while in RUN (see REQ-029).
REQ-012 Parameters SHALL be: PD_CYCLES, default 16, power-down hold length; LOCK_TIMEOUT, default 4096, maximum number of WAIT cycles; STABLE_CYCLES, default 256, number of consecutive locked cycles required; MAX_RETRIES, default 3, number of timeouts tolerated.

Function
REQ-013 PLL_LOCK SHALL pass through a 2-flop synchronizer to give lock_s, a 2-cycle latency; no other logic SHALL sample PLL_LOCK directly.
REQ-014 A single 16-bit cycle counter SHALL be shared by all states and SHALL clear to 0 on every state transition; all parameters SHALL be in the range 1..65535.
REQ-015 PD: PLL_POWERDOWN_N=0; after PD_CYCLES cycles in PD the FSM SHALL go to WAIT.
REQ-016 WAIT: PLL_POWERDOWN_N=1; lock_s=1 -> STABLE on the next edge; after LOCK_TIMEOUT cycles without lock_s -> RETRY_CNT+1 and PD.
REQ-017 WAIT timeout when RETRY_CNT already equals MAX_RETRIES SHALL go to FAULT instead of PD; RETRY_CNT SHALL saturate at 15.
REQ-018 STABLE: the counter SHALL increment while lock_s=1; after STABLE_CYCLES consecutive locked cycles -> RUN; lock_s=0 at any point -> WAIT with the timeout counter restarted and RETRY_CNT unchanged.
REQ-019 RUN: FAB_RST_N=1; RETRY_CNT SHALL clear to 0 on entry; lock_s=0 -> PD on the next edge and FAB_RST_N=0 in the same cycle as the transition.
REQ-020 FAULT: PLL_POWERDOWN_N=0, FAULT=1, FAB_RST_N=0; the FSM SHALL remain in FAULT until RETRY_REQ=1, then -> PD with RETRY_CNT cleared.
REQ-021 RETRY_REQ SHALL be ignored in every state other than FAULT.
REQ-022 All outputs SHALL be registered and decoded from the registered state, so there are no combinational paths from inputs to outputs.
REQ-023 If lock_s falls in the same cycle that the STABLE count completes, the FSM SHALL go to WAIT, because loss of lock has priority.
REQ-024 Timing with default parameters: PLL_LOCK rising at edge t, with the FSM in WAIT, SHALL give FAB_RST_N=1 at edge t+3+STABLE_CYCLES.

Reset
REQ-025 Asserting RST_N SHALL immediately force the following values: STATE=PD, PLL_POWERDOWN_N=0, FAB_RST_N=0, FAULT=0, RETRY_CNT=0, LOSS_CNT=0, counter=0, synchronizer flops=0.
REQ-026 Reset asserted mid-operation, in any state, SHALL abort the sequence without glitching FAB_RST_N high.
REQ-027 After RST_N deasserts, the first state change SHALL be PD->WAIT after PD_CYCLES edges.

Configuration
REQ-028 The macro PLL_SUP_LOSS_CNT_EN SHALL control whether the loss counter is built.
REQ-029 With PLL_SUP_LOSS_CNT_EN defined, LOSS_CNT SHALL increment on each RUN->PD transition caused by lock loss and SHALL saturate at 255.
REQ-030 Without PLL_SUP_LOSS_CNT_EN, LOSS_CNT SHALL be tied to 0, no counter flops SHALL be inferred, and the port list SHALL be unchanged.

Verification
REQ-031 Release RST_N, PLL_LOCK=1 steady -> PLL_POWERDOWN_N rises at edge 16; FAB_RST_N rises at edge 16+3+256=275; STATE=3.
REQ-032 PLL_LOCK held at 0 with defaults -> 3 PD/WAIT cycles with RETRY_CNT=1,2,3; the 4th timeout gives FAULT=1, STATE=4, PLL_POWERDOWN_N=0; then a RETRY_REQ pulse gives STATE=0 and RETRY_CNT=0.
REQ-033 In RUN, a 1-cycle PLL_LOCK drop -> STATE=0 and FAB_RST_N=0 3 edges later; LOSS_CNT goes 0->1 with the macro and stays 0 without it.
REQ-034 In STABLE at count 100, PLL_LOCK drops for 2 cycles -> STATE=1 and FAB_RST_N stays 0; after relock a full 256-cycle recount precedes RUN.
REQ-035 RST_N asserted in RUN and in STABLE -> all outputs reach their reset values asynchronously with no FAB_RST_N pulse; a RETRY_REQ pulse in WAIT -> no effect.
